// File: rtl/nios_pio_pkg.sv
// Shared definitions for the CPU output PIO: register map, status/control bit
// positions and the transfer FSM state type.
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  localparam int ST_BUSY    = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_DONE    = 2;
  localparam int CTL_IRQ_EN = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic [31:0] status_word(input logic busy, input logic ovf,
                                              input logic done);
    logic [31:0] w;
    w          = '0;
    w[ST_BUSY] = busy;
    w[ST_OVF]  = ovf;
    w[ST_DONE] = done;
    return w;
  endfunction

endpackage

// File: rtl/nios_system_cpu_data_out_hs_if.sv
// Avalon-MM slave bus plus the downstream valid/ready output stream of the PIO.
// Handshake: a beat moves on any rising edge where out_valid and out_ready are
// both high; out_port is held stable while out_valid is high and not accepted.
interface nios_system_cpu_data_out_hs_if #(
  parameter int DATA_WIDTH = 8
);
  logic [1:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic [DATA_WIDTH-1:0] out_port;
  logic                  out_valid;
  logic                  out_ready;
  logic                  irq;

  // The master side stands for both the CPU and the downstream consumer.
  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_port, out_valid, irq
  );

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_port, out_valid, irq
  );
endinterface

// File: rtl/nios_system_cpu_data_out_hs.sv
// CPU-written output PIO: a DATA write launches a valid/ready transfer, with
// sticky done/overflow flags, a status register and an optional done interrupt.
module nios_system_cpu_data_out_hs
  import nios_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  nios_system_cpu_data_out_hs_if.slave        bus,
  output state_e                              o_dbg_state
);

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_done;
  logic                  r_ovf;
  logic                  r_irq_en;
  logic [31:0]           r_readdata;

  logic        w_wr;
  logic        w_wr_data;
  logic        w_wr_status;
  logic        w_wr_ctl;
  logic        w_busy;
  logic        w_hs;
  logic        w_done_set;
  logic        w_ovf_set;
  logic [31:0] w_data_ext;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_wr_data   = w_wr & (bus.address == ADDR_DATA);
  assign w_wr_status = w_wr & (bus.address == ADDR_STATUS);
  assign w_wr_ctl    = w_wr & (bus.address == ADDR_CONTROL);

  assign w_busy     = (r_state == BUSY);
  assign w_hs       = w_busy & bus.out_ready;
  assign w_done_set = w_hs;
  // A DATA write while busy is only lost when the current beat is not leaving.
  assign w_ovf_set  = w_busy & ~bus.out_ready & w_wr_data;

  // Upper writedata bits are deliberately discarded.
  assign w_unused = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_data   <= RESET_VALUE;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_data) begin
            r_data  <= bus.writedata[DATA_WIDTH-1:0];
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_hs && w_wr_data) begin
            r_data  <= bus.writedata[DATA_WIDTH-1:0];
            r_state <= BUSY;
          end else if (w_hs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Hardware set wins over a same-cycle software clear.
      r_done <= w_done_set | (r_done & ~(w_wr_status & bus.writedata[ST_DONE]));
      r_ovf  <= w_ovf_set  | (r_ovf  & ~(w_wr_status & bus.writedata[ST_OVF]));

      if (w_wr_ctl) begin
        r_irq_en <= bus.writedata[CTL_IRQ_EN];
      end
    end
  end

  always_comb begin
    w_data_ext                 = '0;
    w_data_ext[DATA_WIDTH-1:0] = r_data;
    w_rd_mux                   = '0;
    case (bus.address)
      ADDR_DATA:    w_rd_mux = w_data_ext;
      ADDR_STATUS:  w_rd_mux = status_word(w_busy, r_ovf, r_done);
      ADDR_CONTROL: w_rd_mux[CTL_IRQ_EN] = r_irq_en;
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign bus.readdata  = r_readdata;
  assign bus.out_port  = r_data;
  assign bus.out_valid = w_busy;
  assign bus.irq       = r_irq_en & r_done;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_nios_system_cpu_data_out_hs.sv
// Bench for the CPU output PIO: directed register-map scenarios with literal
// expectations, then random traffic checked every cycle against a queue model.
module tb_nios_system_cpu_data_out_hs;
  import nios_pio_pkg::*;

  localparam int         DW = 8;
  localparam logic [7:0] RV = 8'h00;

  logic   clk     = 1'b0;
  logic   reset_n = 1'b1;
  state_e dbg_state;

  nios_system_cpu_data_out_hs_if #(.DATA_WIDTH(DW)) bus_if ();

  nios_system_cpu_data_out_hs #(
    .DATA_WIDTH  (DW),
    .RESET_VALUE (RV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus_if.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // At most one beat can be outstanding; a DATA write is accepted when the
  // outstanding slot is free after this edge's hand-off, otherwise it overflows.
  logic [7:0]  pend_q[$];
  logic [7:0]  m_data   = RV;
  bit          m_done   = 1'b0;
  bit          m_ovf    = 1'b0;
  bit          m_irq_en = 1'b0;
  logic [31:0] m_rd     = '0;

  always @(posedge clk or negedge reset_n) begin
    bit wr, set_done, set_ovf;
    if (!reset_n) begin
      pend_q.delete();
      m_data = RV; m_done = 0; m_ovf = 0; m_irq_en = 0; m_rd = '0;
    end else begin
      wr       = bus_if.chipselect && !bus_if.write_n;
      set_done = 0;
      set_ovf  = 0;
      case (bus_if.address)
        2'd0:    m_rd = {24'h0, m_data};
        2'd1:    m_rd = {29'h0, m_done, m_ovf, pend_q.size() != 0};
        2'd2:    m_rd = {31'h0, m_irq_en};
        default: m_rd = '0;
      endcase
      if (pend_q.size() != 0 && bus_if.out_ready) begin
        void'(pend_q.pop_front());
        set_done = 1;
      end
      if (wr && bus_if.address == 2'd0) begin
        if (pend_q.size() == 0) begin
          pend_q.push_back(bus_if.writedata[7:0]);
          m_data = bus_if.writedata[7:0];
        end else set_ovf = 1;
      end
      if (wr && bus_if.address == 2'd1) begin
        if (bus_if.writedata[1]) m_ovf  = 0;
        if (bus_if.writedata[2]) m_done = 0;
      end
      if (set_done) m_done = 1;
      if (set_ovf)  m_ovf  = 1;
      if (wr && bus_if.address == 2'd2) m_irq_en = bus_if.writedata[0];
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_port",  {24'h0, bus_if.out_port}, {24'h0, m_data});
      check("out_valid", {31'h0, bus_if.out_valid}, {31'h0, pend_q.size() != 0});
      check("irq",       {31'h0, bus_if.irq}, {31'h0, m_irq_en & m_done});
      check("readdata",  bus_if.readdata, m_rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.writedata  = data;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic read_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
    bus_if.address = addr;
    tick();
    check(name, bus_if.readdata, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    bus_if.out_ready  = 1'b0;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset values
    check("rst_out_valid", {31'h0, bus_if.out_valid}, 32'h0);
    check("rst_irq",       {31'h0, bus_if.irq}, 32'h0);
    check("rst_out_port",  {24'h0, bus_if.out_port}, 32'h0);
    for (int a = 0; a < 4; a++) read_check("rst_read", 2'(a), 32'h0);

    // Simple transfer
    bus_write(ADDR_DATA, 32'h1A5);
    check("wr_out_port",  {24'h0, bus_if.out_port}, 32'hA5);
    check("wr_out_valid", {31'h0, bus_if.out_valid}, 32'h1);
    read_check("status_busy", ADDR_STATUS, 32'h1);
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    check("hs_out_valid", {31'h0, bus_if.out_valid}, 32'h0);
    read_check("status_done", ADDR_STATUS, 32'h4);

    // Overflow while busy
    bus_write(ADDR_STATUS, 32'h4);
    bus_write(ADDR_DATA, 32'h11);
    bus_write(ADDR_DATA, 32'h22);
    check("ovf_out_port", {24'h0, bus_if.out_port}, 32'h11);
    read_check("status_ovf", ADDR_STATUS, 32'h3);
    bus_write(ADDR_STATUS, 32'h2);
    read_check("status_ovf_clr", ADDR_STATUS, 32'h1);

    // Back-to-back accept in the handshake cycle
    bus_if.out_ready = 1'b1;
    bus_write(ADDR_DATA, 32'h33);
    bus_if.out_ready = 1'b0;
    check("b2b_out_valid", {31'h0, bus_if.out_valid}, 32'h1);
    check("b2b_out_port",  {24'h0, bus_if.out_port}, 32'h33);
    read_check("b2b_status", ADDR_STATUS, 32'h5);
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;

    // Interrupt
    bus_write(ADDR_STATUS, 32'h6);
    bus_write(ADDR_CONTROL, 32'h1);
    check("irq_idle", {31'h0, bus_if.irq}, 32'h0);
    bus_write(ADDR_DATA, 32'h44);
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    check("irq_set", {31'h0, bus_if.irq}, 32'h1);
    bus_write(ADDR_STATUS, 32'h4);
    check("irq_clr", {31'h0, bus_if.irq}, 32'h0);
    bus_write(ADDR_DATA, 32'h55);
    bus_if.out_ready = 1'b1;
    bus_write(ADDR_STATUS, 32'h4);
    bus_if.out_ready = 1'b0;
    check("irq_set_wins", {31'h0, bus_if.irq}, 32'h1);
    read_check("done_set_wins", ADDR_STATUS, 32'h4);

    // Asynchronous reset mid-transfer
    bus_write(ADDR_DATA, 32'h66);
    bus_write(ADDR_DATA, 32'h77);
    check("pre_rst_readdata", bus_if.readdata, 32'h66);
    check("pre_rst_irq", {31'h0, bus_if.irq}, 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_out_valid", {31'h0, bus_if.out_valid}, 32'h0);
    check("arst_out_port",  {24'h0, bus_if.out_port}, 32'h0);
    check("arst_irq",       {31'h0, bus_if.irq}, 32'h0);
    check("arst_readdata",  bus_if.readdata, 32'h0);
    tick();
    reset_n = 1'b1;
    read_check("post_rst_data", ADDR_DATA, {24'h0, RV});
    read_check("post_rst_status", ADDR_STATUS, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic [2:0] a;
      a = 3'($urandom_range(0, 5));
      bus_if.address    = (a > 3'd3) ? 2'd0 : a[1:0];
      bus_if.chipselect = ($urandom_range(0, 3) != 0);
      bus_if.write_n    = ($urandom_range(0, 2) != 0);
      bus_if.writedata  = $urandom;
      bus_if.out_ready  = ($urandom_range(0, 2) == 0);
      tick();
    end
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.out_ready  = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
